// File: rtl/mdu_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU. Fixed latency of Width+1 edges from
// accept to result load; busy stalls the PC, done pulses for one cycle with results valid.
module mdu_divider #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             is_signed_i,
  input  logic [Width-1:0] dividend_i,
  input  logic [Width-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] quotient_o,
  output logic [Width-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int unsigned CntW = $clog2(Width);
  localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e             state_q;
  logic [CntW-1:0]    count_q;
  logic [Width-1:0]   rem_q, quo_q, dmag_q, dividend_q;
  logic               neg_quo_q, neg_rem_q, dbz_q;
  logic [Width-1:0]   quotient_q, remainder_q;
  logic               div_by_zero_q;

  logic               a_neg, b_neg;
  logic [Width-1:0]   a_mag, b_mag;
  logic [Width:0]     rem_sh, rem_step;
  logic               trial_ok;
  logic [Width-1:0]   rem_d, quo_d, quo_fix, rem_fix;

  always_comb begin
    a_neg    = is_signed_i & dividend_i[Width-1];
    b_neg    = is_signed_i & divisor_i[Width-1];
    a_mag    = a_neg ? (~dividend_i + 1'b1) : dividend_i;
    b_mag    = b_neg ? (~divisor_i + 1'b1) : divisor_i;
    // Shift in the next dividend bit from the top of the quotient register.
    rem_sh   = {rem_q, quo_q[Width-1]};
    trial_ok = (rem_sh >= {1'b0, dmag_q});
    rem_step = trial_ok ? (rem_sh - {1'b0, dmag_q}) : rem_sh;
    rem_d    = rem_step[Width-1:0];
    quo_d    = {quo_q[Width-2:0], trial_ok};
    quo_fix  = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix  = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      count_q       <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dmag_q        <= '0;
      dividend_q    <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      dbz_q         <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            state_q    <= StRun;
            count_q    <= '0;
            rem_q      <= '0;
            quo_q      <= a_mag;
            dmag_q     <= b_mag;
            dividend_q <= dividend_i;
            neg_quo_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            dbz_q      <= (divisor_i == '0);
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          rem_q   <= rem_d;
          quo_q   <= quo_d;
          count_q <= count_q + CntW'(1);
          if (count_q == LastCnt) state_q <= StFix;
        end
        StFix: begin
          // A zero divisor overrides the iteration result in both modes.
          quotient_q    <= dbz_q ? '1 : quo_fix;
          remainder_q   <= dbz_q ? dividend_q : rem_fix;
          div_by_zero_q <= dbz_q;
          state_q       <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o        = (state_q == StRun) || (state_q == StFix);
  assign done_o        = (state_q == StDone);
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = div_by_zero_q;

endmodule

// File: tb/tb_mdu_divider.sv
// Bench for mdu_divider: countdown-based reference model checked every cycle, directed
// literal cases, ignored-start and mid-op reset scenarios, then randomized traffic.
module tb_mdu_divider;

  logic        clk = 1'b0;
  logic        rst_n, start, is_signed;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int nchecks = 0;
  int nerrors = 0;

  // Model state: edges left until results load, and the architecturally visible outputs.
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic        m_z = 1'b0, p_z = 1'b0;

  mdu_divider #(.Width(32)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .is_signed_i  (is_signed),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .busy_o       (busy),
    .done_o       (done),
    .quotient_o   (quotient),
    .remainder_o  (remainder),
    .div_by_zero_o(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z);
    int sa, sb;
    z = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else if (!s) begin
      q = a / b; r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else begin
      sa = a; sb = b;
      q = sa / sb; r = sa % sb;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = 0; m_done = 1'b0; m_q = '0; m_r = '0; m_z = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      m_done = (m_left == 0);
      if (m_done) begin
        m_q = p_q; m_r = p_r; m_z = p_z;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        ref_div(is_signed, dividend, divisor, p_q, p_r, p_z);
        m_left = 33;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_left > 0));
    check("done", 32'(done), 32'(m_done));
    check("quotient", quotient, m_q);
    check("remainder", remainder, m_r);
    check("div_by_zero", 32'(div_by_zero), 32'(m_z));
  end

  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; is_signed = 1'($urandom); dividend = $urandom; divisor = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) break;
    end
  endtask

  task automatic directed(input string name, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                          input logic ez);
    logic [31:0] q, r;
    logic        z;
    int          n;
    ref_div(s, a, b, q, r, z);
    check({name, "_model_q"}, q, eq);
    check({name, "_model_r"}, r, er);
    check({name, "_model_z"}, 32'(z), 32'(ez));
    launch(s, a, b);
    wait_done(n);
    check({name, "_latency"}, 32'(n), 32'd33);
    check({name, "_q"}, quotient, eq);
    check({name, "_r"}, remainder, er);
    check({name, "_z"}, 32'(div_by_zero), 32'(ez));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic seen;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_q", quotient, 32'd0);
    check("reset_r", remainder, 32'd0);
    rst_n = 1'b1;

    directed("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    directed("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    directed("div_minneg", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    directed("divu_minneg", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    directed("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);

    // Start pulses during a running op are ignored; start in the done cycle is accepted.
    launch(1'b0, 32'd1000, 32'd3);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) break;
      start = (n == 4 || n == 19);
      is_signed = 1'b1; dividend = 32'd77; divisor = 32'd5;
    end
    check("ignore_latency", 32'(n), 32'd33);
    check("ignore_q", quotient, 32'd333);
    check("ignore_r", remainder, 32'd1);
    start = 1'b1; is_signed = 1'b1; dividend = 32'hFFFF_FF9C; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("b2b_latency", 32'(n), 32'd33);
    check("b2b_q", quotient, 32'hFFFF_FFF2);
    check("b2b_r", remainder, 32'hFFFF_FFFE);

    // Reset asserted at edge +10 of an op discards it.
    launch(1'b0, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_q", quotient, 32'd0);
    check("midrst_r", remainder, 32'd0);
    check("midrst_z", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("midrst_no_done", 32'(seen), 32'd0);

    repeat (6000) begin
      @(negedge clk);
      start     = ($urandom_range(0, 3) == 0);
      is_signed = 1'($urandom);
      dividend  = pick();
      divisor   = pick();
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
